// File: rtl/fighter_ctrl.sv
// fighter_ctrl: per-player fighter state machine between the SoC keycode PIO
// and the sprite renderer. The HID keycode is sampled once per video frame on
// the falling edge of vs; all state advances only on that frame tick.
//
// Ports:
//   Clk_i           system clock
//   Reset_i         asynchronous, active-high reset
//   vs_i            VGA vertical sync, active low, asynchronous to Clk_i
//   keycode_i[7:0]  HID keycode, 0x00 = no key
//   FighterX_o[9:0] sprite left edge
//   FighterY_o[9:0] sprite top edge
//   action_o[2:0]   0 IDLE, 1 WALK, 2 JUMP, 3 PUNCH, 4 KICK, 5 CROUCH
//   anim_frame_o    sprite frame index within the current action
//   facing_left_o   1 = sprite mirrored
//   attack_active_o hit window for collision logic
//
// Build option: define FIGHTER_CROUCH_EN to enable the CROUCH action (key 0x16).
module fighter_ctrl #(
    parameter int unsigned X_MIN        = 0,
    parameter int unsigned X_MAX        = 575,
    parameter int unsigned X_START      = 100,
    parameter int unsigned GROUND_Y     = 300,
    parameter int unsigned WALK_STEP    = 2,
    parameter int unsigned JUMP_V0      = 12,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned PUNCH_FRAMES = 12,
    parameter int unsigned KICK_FRAMES  = 16,
    parameter int unsigned ATK_START    = 4,
    parameter int unsigned ATK_LEN      = 4,
    parameter int unsigned ANIM_DIV     = 6
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       vs_i,
    input  logic [7:0] keycode_i,
    output logic [9:0] FighterX_o,
    output logic [9:0] FighterY_o,
    output logic [2:0] action_o,
    output logic [1:0] anim_frame_o,
    output logic       facing_left_o,
    output logic       attack_active_o
);

    localparam int unsigned CNT_W = 5;

    localparam logic [9:0]        XMIN_V     = 10'(X_MIN);
    localparam logic [9:0]        XMAX_V     = 10'(X_MAX);
    localparam logic [9:0]        XSTART_V   = 10'(X_START);
    localparam logic [9:0]        GROUND_V   = 10'(GROUND_Y);
    localparam logic [9:0]        STEP_V     = 10'(WALK_STEP);
    localparam logic signed [11:0] GROUND_S  = 12'(GROUND_Y);
    localparam logic signed [7:0] V0_V       = 8'(JUMP_V0);
    localparam logic signed [7:0] GRAV_V     = 8'(GRAVITY);
    localparam logic [CNT_W-1:0]  PUNCH_LAST = CNT_W'(PUNCH_FRAMES - 1);
    localparam logic [CNT_W-1:0]  KICK_LAST  = CNT_W'(KICK_FRAMES - 1);
    localparam logic [CNT_W-1:0]  ATK_LO     = CNT_W'(ATK_START);
    localparam logic [CNT_W-1:0]  ATK_HI     = CNT_W'(ATK_START + ATK_LEN);
    localparam logic [CNT_W-1:0]  ADIV_LAST  = CNT_W'(ANIM_DIV - 1);

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_J = 8'h0D;
    localparam logic [7:0] KEY_K = 8'h0E;
`ifdef FIGHTER_CROUCH_EN
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [9:0] CROUCH_Y = 10'(GROUND_Y + 16);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WALK = 3'd1, S_JUMP = 3'd2,
        S_PUNCH = 3'd3, S_KICK = 3'd4, S_CROUCH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WALK = 3'd1, S_JUMP = 3'd2,
        S_PUNCH = 3'd3, S_KICK = 3'd4
    } state_t;
`endif

    logic                    vs_meta_q, vs_sync_q, vs_prev_q, tick;
    state_t                  state_q, state_d;
    logic [9:0]              x_q, x_d, y_q, y_d, x_left, x_right;
    logic signed [7:0]       vy_q, vy_d;
    logic signed [11:0]      y_next;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_last, adiv_q, adiv_d, adiv_base;
    logic [1:0]              anim_q, anim_d, anim_base;
    logic                    face_q, face_d, atk_q, atk_d;
    logic [7:0]              key, key_prev_q, key_prev_d;
    logic                    key_new;

    // Synchronizer flops idle high (vs inactive) so reset release never fakes a tick.
    assign tick     = vs_prev_q & ~vs_sync_q;
    assign key_new  = (key != key_prev_q);
    assign x_left   = (x_q < XMIN_V + STEP_V) ? XMIN_V : x_q - STEP_V;
    assign x_right  = (x_q > XMAX_V - STEP_V) ? XMAX_V : x_q + STEP_V;
    assign y_next   = $signed({2'b00, y_q}) - 12'(vy_q);
    assign cnt_last = (state_q == S_PUNCH) ? PUNCH_LAST : KICK_LAST;
    // A fresh WALK entry starts its divider from zero.
    assign adiv_base = (state_q == S_WALK) ? adiv_q : '0;
    assign anim_base = (state_q == S_WALK) ? anim_q : '0;

    // Unrecognised keycodes behave exactly like "no key".
    always_comb begin
        key = '0;
        case (keycode_i)
            KEY_A, KEY_D, KEY_W, KEY_J, KEY_K: key = keycode_i;
`ifdef FIGHTER_CROUCH_EN
            KEY_S: key = keycode_i;
`endif
            default: key = '0;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            vs_meta_q  <= 1'b1;
            vs_sync_q  <= 1'b1;
            vs_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            x_q        <= XSTART_V;
            y_q        <= GROUND_V;
            vy_q       <= '0;
            cnt_q      <= '0;
            adiv_q     <= '0;
            anim_q     <= '0;
            face_q     <= 1'b0;
            atk_q      <= 1'b0;
            key_prev_q <= '0;
        end else begin
            vs_meta_q  <= vs_i;
            vs_sync_q  <= vs_meta_q;
            vs_prev_q  <= vs_sync_q;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            cnt_q      <= cnt_d;
            adiv_q     <= adiv_d;
            anim_q     <= anim_d;
            face_q     <= face_d;
            atk_q      <= atk_d;
            key_prev_q <= key_prev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        cnt_d      = cnt_q;
        adiv_d     = adiv_q;
        anim_d     = anim_q;
        face_d     = face_q;
        atk_d      = atk_q;
        key_prev_d = key_prev_q;
        if (tick) begin
            key_prev_d = key;
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (key == KEY_J && key_new) begin
                        state_d = S_PUNCH;
                        cnt_d   = '0;
                    end else if (key == KEY_K && key_new) begin
                        state_d = S_KICK;
                        cnt_d   = '0;
                    end else if (key == KEY_W) begin
                        state_d = S_JUMP;
                        vy_d    = V0_V;
`ifdef FIGHTER_CROUCH_EN
                    end else if (key == KEY_S) begin
                        state_d = S_CROUCH;
                        y_d     = CROUCH_Y;
`endif
                    end else if (key == KEY_A) begin
                        state_d = S_WALK;
                        x_d     = x_left;
                        face_d  = 1'b1;
                    end else if (key == KEY_D) begin
                        state_d = S_WALK;
                        x_d     = x_right;
                        face_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_JUMP: begin
                    if (key == KEY_A)      x_d = x_left;
                    else if (key == KEY_D) x_d = x_right;
                    if (y_next >= GROUND_S) begin
                        state_d = S_IDLE;
                        y_d     = GROUND_V;
                        vy_d    = '0;
                    end else begin
                        y_d  = y_next[9:0];
                        vy_d = vy_q - GRAV_V;
                    end
                end
                S_PUNCH, S_KICK: begin
                    if (cnt_q == cnt_last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        y_d     = GROUND_V;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef FIGHTER_CROUCH_EN
                S_CROUCH: begin
                    if (key == KEY_S) begin
                        state_d = S_CROUCH;
                    end else if (key == KEY_J && key_new) begin
                        state_d = S_PUNCH;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        y_d     = GROUND_V;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase

            // Animation and hit window always follow the state being entered.
            adiv_d = '0;
            anim_d = '0;
            case (state_d)
                S_WALK: begin
                    if (adiv_base == ADIV_LAST) begin
                        anim_d = anim_base + 2'd1;
                    end else begin
                        adiv_d = adiv_base + CNT_W'(1);
                        anim_d = anim_base;
                    end
                end
                S_PUNCH, S_KICK: anim_d = (cnt_d[CNT_W-1:2] > 3'd3) ? 2'd3 : cnt_d[3:2];
                default: ;
            endcase
            atk_d = (state_d == S_PUNCH || state_d == S_KICK) &&
                    (cnt_d >= ATK_LO) && (cnt_d < ATK_HI);
        end
    end

    always_comb begin
        FighterX_o      = x_q;
        FighterY_o      = y_q;
        action_o        = state_q;
        anim_frame_o    = anim_q;
        facing_left_o   = face_q;
        attack_active_o = atk_q;
    end

endmodule

// File: tb/tb_fighter_ctrl.sv
// Testbench for fighter_ctrl: directed frames push expected outputs into a
// scoreboard; a monitor pops and compares after each frame's update edge.
module tb_fighter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs  = 1'b1;
    logic [7:0] key = '0;
    logic [9:0] fx, fy;
    logic [2:0] act;
    logic [1:0] anim;
    logic       face, atk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] act;
        logic [1:0] anim;
        logic       face;
        logic       atk;
    } exp_t;

    exp_t  sb[$];
    string tags[$];

    always #5 clk = ~clk;

    fighter_ctrl dut (
        .Clk_i          (clk),
        .Reset_i        (rst),
        .vs_i           (vs),
        .keycode_i      (key),
        .FighterX_o     (fx),
        .FighterY_o     (fy),
        .action_o       (act),
        .anim_frame_o   (anim),
        .facing_left_o  (face),
        .attack_active_o(atk)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input int a,
                                input int an, input int f, input int at);
        exp_t e;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.act  = 3'(a);
        e.anim = 2'(an);
        e.face = 1'(f);
        e.atk  = 1'(at);
        return e;
    endfunction

    task automatic check_reset(input string t);
        cmp({t, ".x"},    32'(fx),   32'd100);
        cmp({t, ".y"},    32'(fy),   32'd300);
        cmp({t, ".act"},  32'(act),  32'd0);
        cmp({t, ".anim"}, 32'(anim), 32'd0);
        cmp({t, ".face"}, 32'(face), 32'd0);
        cmp({t, ".atk"},  32'(atk),  32'd0);
    endtask

    // One video frame: key is held across the vs falling edge and its tick.
    task automatic frame(input logic [7:0] k, input string tag, input exp_t e);
        key = k;
        sb.push_back(e);
        tags.push_back(tag);
        @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        vs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: outputs settle on the 3rd clock edge after vs falls.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge vs);
            repeat (3) @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick got tick want none");
            end else begin
                e = sb.pop_front();
                t = tags.pop_front();
                cmp({t, ".x"},    32'(fx),   32'(e.x));
                cmp({t, ".y"},    32'(fy),   32'(e.y));
                cmp({t, ".act"},  32'(act),  32'(e.act));
                cmp({t, ".anim"}, 32'(anim), 32'(e.anim));
                cmp({t, ".face"}, 32'(face), 32'(e.face));
                cmp({t, ".atk"},  32'(atk),  32'(e.atk));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, a, an, at;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Walk right: +2 per frame, anim steps every 6th frame.
        for (int i = 1; i <= 12; i++)
            frame(8'h07, "walkR", mk(100 + 2 * i, 300, 1, (i / 6) % 4, 0, 0));
        frame(8'h00, "stopR", mk(124, 300, 0, 0, 0, 0));

        // Walk left into X_MIN clamp, passing through X=4,2,0.
        for (int i = 1; i <= 66; i++) begin
            x = 124 - 2 * i;
            if (x < 0) x = 0;
            frame(8'h04, "walkL", mk(x, 300, 1, (i / 6) % 4, 1, 0));
        end
        frame(8'h00, "stopL", mk(0, 300, 0, 0, 1, 0));

        // Jump: entry tick holds Y; then Y -= 12,11,...; steer right 3 frames.
        frame(8'h1A, "jump0", mk(0, 300, 2, 0, 1, 0));
        for (int k = 1; k <= 25; k++) begin
            y = 300 - (12 * k - (k * (k - 1)) / 2);
            x = (k <= 3) ? 2 * k : 6;
            frame((k <= 3) ? 8'h07 : 8'h00, (k == 12) ? "jumpPeak" : "jump",
                  mk(x, y, (k == 25) ? 0 : 2, 0, 1, 0));
        end
        frame(8'h00, "landed", mk(6, 300, 0, 0, 1, 0));

        // Held J: one punch of 12 frames, hit window frames 5..8, no retrigger.
        for (int i = 1; i <= 30; i++) begin
            a  = (i <= 12) ? 3 : 0;
            an = (i <= 12) ? ((i - 1) >> 2) : 0;
            at = (i >= 5 && i <= 8) ? 1 : 0;
            frame(8'h0D, "punchHeld", mk(6, 300, a, an, 1, at));
        end
        frame(8'h00, "release", mk(6, 300, 0, 0, 1, 0));
        frame(8'h0D, "retrig", mk(6, 300, 3, 0, 1, 0));
        // Unlisted keycode 0x05 behaves as no key; punch runs to completion.
        for (int i = 2; i <= 13; i++) begin
            a  = (i <= 12) ? 3 : 0;
            an = (i <= 12) ? ((i - 1) >> 2) : 0;
            at = (i >= 5 && i <= 8) ? 1 : 0;
            frame(8'h05, "punch2", mk(6, 300, a, an, 1, at));
        end

`ifdef FIGHTER_CROUCH_EN
        frame(8'h16, "crouch", mk(6, 316, 5, 0, 1, 0));
        frame(8'h16, "crouchHold", mk(6, 316, 5, 0, 1, 0));
`else
        frame(8'h16, "key16", mk(6, 300, 0, 0, 1, 0));
`endif
        frame(8'h00, "stand", mk(6, 300, 0, 0, 1, 0));

        // Kick up to cnt=7, then asynchronous reset between clock edges.
        for (int i = 1; i <= 8; i++)
            frame(8'h0E, "kick", mk(6, 300, 4, (i - 1) >> 2, 1, (i >= 5) ? 1 : 0));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("rstKick");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame(8'h00, "postRst", mk(100, 300, 0, 0, 0, 0));

        // Full kick: 16 frames then IDLE.
        for (int i = 1; i <= 17; i++) begin
            a  = (i <= 16) ? 4 : 0;
            an = (i <= 16) ? ((i - 1) >> 2) : 0;
            at = (i >= 5 && i <= 8) ? 1 : 0;
            frame(8'h0E, "kick2", mk(100, 300, a, an, 0, at));
        end

        // Walk right into X_MAX clamp (574 -> 575).
        for (int i = 1; i <= 240; i++) begin
            x = 100 + 2 * i;
            if (x > 575) x = 575;
            frame(8'h07, "walkMax", mk(x, 300, 1, (i / 6) % 4, 0, 0));
        end

        repeat (10) @(negedge clk);
        cmp("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
